// File: rtl/shadow_pkg.sv
// ---------------------------------------------------------------------------
// shadow_pkg
//
// Shared definitions for the interrupt shadow-bank spill/fill controller.
//   NUM_SHADOW  : number of integer registers covered by the shadow bank
//   SHADOW_MAP  : shadow slot -> architectural register index
//   FRAME_BYTES : size in bytes of one saved stack frame for a given XLEN
//   spill_state_e : sequencing states of shadow_spill_ctrl
// ---------------------------------------------------------------------------
package shadow_pkg;

   localparam int NUM_SHADOW = 16;

   // Slot k of the shadow bank holds architectural register SHADOW_MAP[k].
   // The frame in memory is laid out in the same slot order.
   localparam logic [4:0] SHADOW_MAP [NUM_SHADOW] = '{
      5'd1,  5'd5,  5'd6,  5'd7,
      5'd10, 5'd11, 5'd12, 5'd13,
      5'd14, 5'd15, 5'd16, 5'd17,
      5'd28, 5'd29, 5'd30, 5'd31
   };

   // Bytes occupied by one full frame, used to undo the sp bump on mret.
   function automatic int FRAME_BYTES(input int xlen);
      return NUM_SHADOW * xlen / 8;
   endfunction

   typedef enum logic [3:0] {
      IDLE,
      SAVE,
      SPILL_REQ,
      SPILL_WAIT,
      FILL_REQ,
      FILL_WAIT,
      FILL_WB,
      SP_FIX,
      DONE
   } spill_state_e;

endpackage

// File: rtl/shadow_spill_ctrl.sv
// ---------------------------------------------------------------------------
// shadow_spill_ctrl
//
// Sequences the integer-register shadow bank for fast interrupt entry/exit.
// Entry: one-cycle snapshot strobe (which also bumps sp in the regfile), then
// the 16 shadowed registers are stored to the new frame one request at a
// time. mret: the frame is loaded back word by word and written into the
// architectural registers through an arbitrated write port, then sp is
// restored to the value it had before the entry bump.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   irq_entry_valid_i/ready_o    save-context handshake
//   mret_valid_i/ready_o         restore-context handshake
//   busy_o                       controller is not idle
//   done_o, err_o                end-of-operation pulse and its error flag
//   shadow_save_o, next_sp_i     snapshot strobe and post-bump sp
//   shadow_raddr_o, shadow_rdata_i  shadow bank read port (combinational)
//   req_* / rsp_*                single-outstanding load/store port
//   rf_we_o, rf_gnt_i, rf_waddr_o, rf_wdata_o  arbitrated regfile write
// ---------------------------------------------------------------------------
module shadow_spill_ctrl #(
   parameter int XLEN       = 64,
   parameter int NUM_SHADOW = 16,
   parameter int SP_REG     = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            irq_entry_valid_i,
   output logic            irq_entry_ready_o,
   input  logic            mret_valid_i,
   output logic            mret_ready_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic            shadow_save_o,
   input  logic [XLEN-1:0] next_sp_i,
   output logic [3:0]      shadow_raddr_o,
   input  logic [XLEN-1:0] shadow_rdata_i,
   output logic            req_valid_o,
   input  logic            req_ready_i,
   output logic            req_we_o,
   output logic [XLEN-1:0] req_addr_o,
   output logic [XLEN-1:0] req_wdata_o,
   input  logic            rsp_valid_i,
   input  logic [XLEN-1:0] rsp_rdata_i,
   input  logic            rsp_err_i,
   output logic            rf_we_o,
   input  logic            rf_gnt_i,
   output logic [4:0]      rf_waddr_o,
   output logic [XLEN-1:0] rf_wdata_o
);

   import shadow_pkg::*;

   localparam logic [3:0]      LAST_IDX   = 4'(NUM_SHADOW - 1);
   localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(XLEN / 8);
   localparam logic [XLEN-1:0] FRAME_SIZE = XLEN'(FRAME_BYTES(XLEN));

   spill_state_e    state;
   logic [3:0]      idx;
   logic [XLEN-1:0] base;
   logic            err;
   logic [XLEN-1:0] rdata;
   logic [XLEN-1:0] slot_addr;

   // Address of the current slot within the frame; wraps naturally at
   // 2^XLEN because the adder is exactly XLEN bits wide.
   assign slot_addr = base + XLEN'(idx) * WORD_BYTES;

   // Main sequencer. A simultaneous entry and mret in IDLE resolves to entry
   // since entry is checked first and mret_ready_o is gated off by it.
   // Responses are only consumed in the *_WAIT states, so a stray or late
   // response (e.g. one that arrives after a reset) has no effect.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         idx   <= '0;
         base  <= '0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (irq_entry_valid_i) begin
                  state <= SAVE;
               end else if (mret_valid_i) begin
                  state <= FILL_REQ;
                  idx   <= '0;
                  err   <= 1'b0;
               end
            end
            SAVE: begin
               base  <= next_sp_i;
               idx   <= '0;
               err   <= 1'b0;
               state <= SPILL_REQ;
            end
            SPILL_REQ: begin
               if (req_ready_i) state <= SPILL_WAIT;
            end
            SPILL_WAIT: begin
               if (rsp_valid_i) begin
                  err <= err | rsp_err_i;
                  if (idx == LAST_IDX) begin
                     state <= DONE;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= SPILL_REQ;
                  end
               end
            end
            FILL_REQ: begin
               if (req_ready_i) state <= FILL_WAIT;
            end
            FILL_WAIT: begin
               if (rsp_valid_i) begin
                  rdata <= rsp_rdata_i;
                  err   <= err | rsp_err_i;
                  state <= FILL_WB;
               end
            end
            FILL_WB: begin
               if (rf_gnt_i) begin
                  if (idx == LAST_IDX) begin
                     state <= SP_FIX;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= FILL_REQ;
                  end
               end
            end
            SP_FIX: begin
               if (rf_gnt_i) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Handshake outputs. mret is held off whenever an entry is being offered
   // so the core never sees both accepted in the same cycle.
   assign irq_entry_ready_o = (state == IDLE);
   assign mret_ready_o      = (state == IDLE) && !irq_entry_valid_i;
   assign busy_o            = (state != IDLE);
   assign shadow_raddr_o    = idx;

   // State-decoded datapath outputs. Everything not owned by the current
   // state is driven to zero. Request fields derive only from base/idx and
   // the shadow bank read at idx, so they stay stable while a request waits
   // for req_ready_i.
   always_comb begin
      done_o        = 1'b0;
      err_o         = 1'b0;
      shadow_save_o = 1'b0;
      req_valid_o   = 1'b0;
      req_we_o      = 1'b0;
      req_addr_o    = '0;
      req_wdata_o   = '0;
      rf_we_o       = 1'b0;
      rf_waddr_o    = '0;
      rf_wdata_o    = '0;
      case (state)
         SAVE: begin
            shadow_save_o = 1'b1;
         end
         SPILL_REQ: begin
            req_valid_o = 1'b1;
            req_we_o    = 1'b1;
            req_addr_o  = slot_addr;
            req_wdata_o = shadow_rdata_i;
         end
         FILL_REQ: begin
            req_valid_o = 1'b1;
            req_addr_o  = slot_addr;
         end
         FILL_WB: begin
            rf_we_o    = 1'b1;
            rf_waddr_o = SHADOW_MAP[idx];
            rf_wdata_o = rdata;
         end
         SP_FIX: begin
            rf_we_o    = 1'b1;
            rf_waddr_o = 5'(SP_REG);
            rf_wdata_o = base + FRAME_SIZE;
         end
         DONE: begin
            done_o = 1'b1;
            err_o  = err;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/shadow_spill_ctrl.md
Name: shadow_spill_ctrl

Overview:
- Sequences the integer-register shadow bank for fast interrupt entry and exit.
- On interrupt entry it fires the one-cycle shadow snapshot, which also bumps sp. It then spills the 16 shadowed registers to the new stack frame in the background through a single-outstanding memory port.
- On mret it reloads the frame into the architectural registers through an arbitrated regfile write port, then restores sp.
- Sits between the interrupt controller/CSR unit, the register file and a load/store memory port.

Parameters:
- XLEN, 64, datapath and address width.
- NUM_SHADOW, 16, number of shadowed registers; fixed, must match the package constant.
- SP_REG, 2, architectural index of sp.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- irq_entry_valid_i  in  1  request to save context
- irq_entry_ready_o  out  1  entry accepted when valid&&ready
- mret_valid_i  in  1  request to restore context
- mret_ready_o  out  1  restore accepted when valid&&ready
- busy_o  out  1  any non-IDLE state
- done_o  out  1  one-cycle pulse at end of spill or restore
- err_o  out  1  qualifies done_o: a response error occurred during that operation
- shadow_save_o  out  1  one-cycle snapshot strobe to the regfile
- next_sp_i  in  XLEN  post-bump sp from the regfile, valid while shadow_save_o=1
- shadow_raddr_o  out  4  shadow bank read index
- shadow_rdata_i  in  XLEN  shadow bank read data, combinational
- req_valid_o  out  1  memory request
- req_ready_i  in  1  memory accept
- req_we_o  out  1  1=store, 0=load
- req_addr_o  out  XLEN  byte address
- req_wdata_o  out  XLEN  store data
- rsp_valid_i  in  1  response, one per request
- rsp_rdata_i  in  XLEN  load data
- rsp_err_i  in  1  bus error
- rf_we_o  out  1  regfile write request
- rf_gnt_i  in  1  write granted this cycle
- rf_waddr_o  out  5  architectural destination
- rf_wdata_o  out  XLEN  write data

Behaviour:
- Reset: state IDLE, idx=0, base=0, err flag=0. All outputs 0 except the ready outputs, which are 1.
- Ready rules: irq_entry_ready_o=1 only in IDLE. mret_ready_o=1 only in IDLE with irq_entry_valid_i=0. Entry wins a simultaneous request.
- IDLE -> SAVE on accepted entry. IDLE -> FILL_REQ on accepted mret; idx=0, err=0.
- SAVE (1 cycle):
  - shadow_save_o=1.
  - base <= next_sp_i; idx <= 0; err <= 0.
  - Next state SPILL_REQ.
- SPILL_REQ:
  - Outputs: req_valid_o=1, req_we_o=1, shadow_raddr_o=idx, req_wdata_o=shadow_rdata_i, req_addr_o=base+idx*(XLEN/8), modulo 2^XLEN.
  - Request fields must be stable while req_valid_o=1 and not accepted.
  - On req_ready_i -> SPILL_WAIT.
- SPILL_WAIT:
  - On rsp_valid_i: err |= rsp_err_i.
  - If idx==15 -> DONE, else idx++ -> SPILL_REQ.
- FILL_REQ:
  - Outputs: req_valid_o=1, req_we_o=0, same address formula; base holds the frame captured at the last SAVE.
  - On req_ready_i -> FILL_WAIT.
- FILL_WAIT:
  - On rsp_valid_i: latch rdata; err |= rsp_err_i.
  - Next state FILL_WB.
  - A load error still writes the returned data.
- FILL_WB:
  - rf_we_o=1, rf_waddr_o=SHADOW_MAP[idx], rf_wdata_o=latched data; held until rf_gnt_i.
  - On grant: if idx==15 -> SP_FIX, else idx++ -> FILL_REQ.
- SP_FIX:
  - rf_we_o=1, rf_waddr_o=SP_REG, rf_wdata_o=base+NUM_SHADOW*(XLEN/8); held until rf_gnt_i.
  - On grant -> DONE.
- DONE (1 cycle): done_o=1, err_o=err. Next state IDLE.
- Ordering and timing:
  - At most one outstanding memory request.
  - rsp_valid_i outside a *_WAIT state is ignored.
  - Minimum latencies with zero-wait memory and arbiter: spill = 1 (SAVE) + 16*2 + 1 (DONE) = 34 cycles. Restore = 16*3 + 1 (SP_FIX) + 1 (DONE) = 50 cycles.
- Architectural interlock: the core stalls mret issue while busy_o=1. Nested entry is not accepted until DONE.
- Reset mid-operation: returns to IDLE immediately; the partial frame is abandoned. A late response arriving after reset is ignored.

Decomposition:
- Package shadow_pkg:
  - NUM_SHADOW=16.
  - SHADOW_MAP[16] of 5-bit = {1,5,6,7,10,11,12,13,14,15,16,17,28,29,30,31}.
  - FRAME_BYTES(XLEN)=NUM_SHADOW*XLEN/8.
  - State enum spill_state_e.
- Single module, no sub-module. The address generator is a single adder and stays inline.

Test Plan:
- Spill, zero-wait: XLEN=64, next_sp_i=0x8000_0F80 at SAVE, shadow bank word k=0x1000+k -> 16 stores to 0x8000_0F80+8k with data 0x1000+k, in order; done_o at cycle 34, err_o=0.
- Restore with backpressure: memory returns 0xA0+k; req_ready_i low for 3 cycles per request; rf_gnt_i low every other cycle -> writes go to x1,x5,x6,x7,x10..x17,x28..x31 with 0xA0..0xAF, then x2=0x8000_1000; done_o asserted, err_o=0.
- Simultaneous irq_entry_valid_i and mret_valid_i in IDLE -> entry accepted, mret_ready_o=0; mret accepted only after done_o.
- rsp_err_i=1 on store idx 5 -> spill continues through idx 15; done_o with err_o=1; err cleared on the next operation.
- rst_i asserted during FILL_WAIT at idx 7, then rsp_valid_i arrives -> IDLE, no rf_we_o, all outputs at reset values, ready outputs=1.
- Address wrap: next_sp_i=0xFFFF_FFFF_FFFF_FFC0 -> the idx 8 store address is 0x0000_0000_0000_0000.
